// File: rtl/attn_param_stream_mux_pkg.sv
// attn_stream_pkg: shared defaults, FSM state type and index-width helper
// for the attention-head parameter stream mux.
package attn_stream_pkg;

   localparam int D_W_DEF     = 32;
   localparam int LEN_W_DEF   = 24;
   localparam int NUM_SEG_DEF = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SEND  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   function automatic int seg_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/attn_param_stream_mux_if.sv
// Stream bundle for the mux: NUM_SEG input channels (s_*) and one
// serialised output (m_*). master = mux side, slave = environment side.
interface attn_param_stream_mux_if
   import attn_stream_pkg::*;
#(
   parameter int D_W     = D_W_DEF,
   parameter int NUM_SEG = NUM_SEG_DEF
);

   logic [NUM_SEG*D_W-1:0] s_tdata;
   logic [NUM_SEG-1:0]     s_tvalid;
   logic [NUM_SEG-1:0]     s_tready;
   logic [D_W-1:0]         m_tdata;
   logic                   m_tvalid;
   logic                   m_tready;
   logic                   m_tlast;

   modport master (
      input  s_tdata, s_tvalid, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast
   );

   modport slave (
      output s_tdata, s_tvalid, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast
   );

endinterface

// File: rtl/attn_param_stream_mux_skid.sv
// axis_skid_buf: 2-entry registered buffer, valid/ready on both sides.
// Ports: clk, rst, in_* (push), out_* (pop), level = occupancy 0..2.
module axis_skid_buf #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   level
);

   logic [W-1:0] mem [2];
   logic         wp;
   logic         rp;
   logic [1:0]   cnt;
   logic         push;
   logic         pop;

   assign in_ready  = (cnt != 2'd2);
   assign out_valid = (cnt != 2'd0);
   assign out_data  = mem[rp];
   assign level     = cnt;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wp] <= in_data;
            wp      <= ~wp;
         end
         if (pop)
            rp <= ~rp;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/attn_param_stream_mux.sv
// attn_param_stream_mux: serialises NUM_SEG channels, segment i = len[i] beats.
// Ports: clk, rst, start, seg_len_flat, bus (s_*/m_*), busy, done. Macro: ATTN_MUX_SEG_LAST_EN.
module attn_param_stream_mux
   import attn_stream_pkg::*;
#(
   parameter int D_W     = D_W_DEF,
   parameter int NUM_SEG = NUM_SEG_DEF,
   parameter int LEN_W   = LEN_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [NUM_SEG*LEN_W-1:0] seg_len_flat,
   attn_param_stream_mux_if.master  bus,
   output logic                     busy,
   output logic                     done
);

   localparam int SEG_W = seg_w(NUM_SEG);

   state_t           state;
   logic [SEG_W-1:0] seg_idx;
   logic [LEN_W-1:0] beat_cnt;
   logic [LEN_W-1:0] len_r [NUM_SEG];

   logic [SEG_W:0]   lo;
   logic             nxt_found;
   logic [SEG_W-1:0] nxt_idx;
   logic [D_W-1:0]   sel_data;
   logic             sel_valid;
   logic             in_ready;
   logic             take;
   logic             seg_last;
   logic             tag_last;
   logic [D_W:0]     out_data;
   logic             out_valid;
   logic [1:0]       level;

   // Search origin: whole table in LOAD, past the current segment in SEND.
   assign lo = (state == LOAD) ? '0
             : {1'b0, seg_idx} + (SEG_W+1)'(1);

   always_comb begin
      nxt_found = 1'b0;
      nxt_idx   = '0;
      for (int i = NUM_SEG-1; i >= 0; i--) begin
         if (len_r[i] != '0 && i >= int'(lo)) begin
            nxt_found = 1'b1;
            nxt_idx   = SEG_W'(i);
         end
      end
   end

   assign sel_data  = bus.s_tdata[seg_idx*D_W +: D_W];
   assign sel_valid = bus.s_tvalid[seg_idx];
   assign take      = (state == SEND) & sel_valid & in_ready;
   assign seg_last  = (beat_cnt == len_r[seg_idx] - LEN_W'(1));

`ifdef ATTN_MUX_SEG_LAST_EN
   assign tag_last = seg_last;
`else
   assign tag_last = seg_last & ~nxt_found;
`endif

   always_comb begin
      bus.s_tready = '0;
      if (state == SEND)
         bus.s_tready[seg_idx] = in_ready;
   end

   axis_skid_buf #(.W(D_W+1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({tag_last, sel_data}),
      .in_valid  ((state == SEND) & sel_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (bus.m_tready),
      .level     (level)
   );

   assign bus.m_tdata  = out_data[D_W-1:0];
   assign bus.m_tlast  = out_data[D_W];
   assign bus.m_tvalid = out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         seg_idx  <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int i = 0; i < NUM_SEG; i++)
            len_r[i] <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_SEG; i++)
                     len_r[i] <= seg_len_flat[i*LEN_W +: LEN_W];
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               beat_cnt <= '0;
               if (nxt_found) begin
                  seg_idx <= nxt_idx;
                  state   <= SEND;
               end else begin
                  state <= DRAIN;
               end
            end
            SEND: begin
               if (take) begin
                  if (seg_last) begin
                     beat_cnt <= '0;
                     if (nxt_found)
                        seg_idx <= nxt_idx;
                     else
                        state <= DRAIN;
                  end else begin
                     beat_cnt <= beat_cnt + LEN_W'(1);
                  end
               end
            end
            DRAIN: begin
               // Finish when the buffer is empty or its last beat leaves now.
               if (level == 2'd0 ||
                   (level == 2'd1 && bus.m_tready)) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  seg_idx <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_attn_param_stream_mux.sv
// Directed bench for attn_param_stream_mux with three channels.
// Checks beat order, tlast, done timing, handshake rules and reset.
module tb_attn_param_stream_mux;

   localparam int D_W = 32;
   localparam int NS  = 3;
   localparam int LW  = 24;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [NS*LW-1:0] seg_len_flat = '0;
   logic             busy;
   logic             done;

   attn_param_stream_mux_if #(.D_W(D_W), .NUM_SEG(NS)) sif ();

   attn_param_stream_mux #(.D_W(D_W), .NUM_SEG(NS), .LEN_W(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .seg_len_flat (seg_len_flat),
      .bus          (sif.master),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          last_hs = 0;
   int          done_cyc = 0;
   int          done_cnt = 0;
   int          viol = 0;
   int          occ = 0;
   int          busy_ticks = 0;
   int          cnt [NS];
   logic [2:0]  rdy_seen;
   bit          rnd_rdy = 1'b0;
   bit          stall_pend = 1'b0;
   bit          tv_seen = 1'b0;
   logic [32:0] stall_beat;
   logic [32:0] rx [$];

   function automatic logic [31:0] mk(input int c, input int k);
      return 32'hA500_0000 | (32'(c) << 16) | 32'(k);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_src();
      for (int c = 0; c < NS; c++)
         sif.s_tdata[c*D_W +: D_W] = mk(c, cnt[c]);
   endtask

   task automatic clear();
      rx.delete();
      done_cnt   = 0;
      viol       = 0;
      rdy_seen   = '0;
      tv_seen    = 1'b0;
      stall_pend = 1'b0;
      busy_ticks = 0;
      for (int c = 0; c < NS; c++)
         cnt[c] = 0;
      drive_src();
   endtask

   // Sample at negedge, advance clock, update upstream/downstream drivers.
   task automatic tick();
      logic [2:0]  hs;
      logic [32:0] beat;
      int          pop;
      cyc++;
      beat = {sif.m_tlast, sif.m_tdata};
      pop  = (sif.m_tvalid && sif.m_tready) ? 1 : 0;
      if (pop == 1) begin
         rx.push_back(beat);
         last_hs = cyc;
      end
      if (sif.m_tvalid) tv_seen = 1'b1;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy === 1'b1) busy_ticks++;
      if ($countones(sif.s_tready) > 1) viol++;
      rdy_seen |= sif.s_tready;
      if (stall_pend && (sif.m_tvalid !== 1'b1 || beat !== stall_beat))
         viol++;
      stall_pend = sif.m_tvalid && !sif.m_tready;
      stall_beat = beat;
      hs = sif.s_tvalid & sif.s_tready;
      if (occ == 2 && sif.s_tready != '0) viol++;
      occ = occ + $countones(hs) - pop;
      if (rst) begin
         occ        = 0;
         stall_pend = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NS; c++)
         if (hs[c] && !rst) cnt[c]++;
      drive_src();
      if (rnd_rdy) sif.m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
   endtask

   task automatic run_pkt(input string tag, input int l0, input int l1,
                          input int l2, input bit mid);
      logic [32:0] exp [$];
      int          lens [NS];
      int          ln;
      int          k;
      bit          lst;
      clear();
      lens[0] = l0;
      lens[1] = l1;
      lens[2] = l2;
      ln = -1;
      for (int c = 0; c < NS; c++)
         if (lens[c] != 0) ln = c;
      for (int c = 0; c < NS; c++)
         for (int b = 0; b < lens[c]; b++) begin
`ifdef ATTN_MUX_SEG_LAST_EN
            lst = (b == lens[c] - 1);
`else
            lst = (c == ln) && (b == lens[c] - 1);
`endif
            exp.push_back({lst, mk(c, b)});
         end
      seg_len_flat = {LW'(l2), LW'(l1), LW'(l0)};
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (done_cnt == 0 && k < 400) begin
         if (mid && k == 3) begin
            start = 1'b1;
            seg_len_flat = {LW'(7), LW'(7), LW'(7)};
         end else if (mid && k == 4) begin
            start = 1'b0;
         end
         tick();
         k++;
      end
      chk({tag, "_no_timeout"}, 64'(k < 400), 64'd1);
      repeat (4) tick();
      chk({tag, "_beats"}, 64'(rx.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < rx.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), 64'(rx[i]), 64'(exp[i]));
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      if (exp.size() != 0)
         chk({tag, "_done_lat"}, 64'(done_cyc), 64'(last_hs + 1));
      chk({tag, "_hs_rules"}, 64'(viol), 64'd0);
      chk({tag, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int k;
      sif.s_tvalid = '1;
      sif.m_tready = 1'b1;
      clear();
      @(negedge clk);
      repeat (3) tick();
      chk("rst_m_tvalid", 64'(sif.m_tvalid), 64'd0);
      chk("rst_m_tlast", 64'(sif.m_tlast), 64'd0);
      chk("rst_m_tdata", 64'(sif.m_tdata), 64'd0);
      chk("rst_s_tready", 64'(sif.s_tready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      occ = 0;

      run_pkt("t1", 2, 3, 1, 1'b0);

      run_pkt("t2", 0, 4, 0, 1'b0);
      chk("t2_rdy_seen", 64'(rdy_seen), 64'b010);

      run_pkt("t3", 0, 0, 0, 1'b0);
      chk("t3_no_tvalid", 64'(tv_seen), 64'd0);
      chk("t3_busy_lat", 64'(busy_ticks <= 3), 64'd1);

      rnd_rdy = 1'b1;
      run_pkt("t4", 5, 5, 5, 1'b0);
      rnd_rdy = 1'b0;
      sif.m_tready = 1'b1;

      clear();
      seg_len_flat = {LW'(1), LW'(3), LW'(2)};
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (rx.size() < 3 && k < 50) begin
         tick();
         k++;
      end
      chk("t5_partial", 64'(rx.size()), 64'd3);
      rst = 1'b1;
      tick();
      chk("t5_m_tvalid", 64'(sif.m_tvalid), 64'd0);
      chk("t5_m_tlast", 64'(sif.m_tlast), 64'd0);
      chk("t5_m_tdata", 64'(sif.m_tdata), 64'd0);
      chk("t5_s_tready", 64'(sif.s_tready), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      rst = 1'b0;
      occ = 0;
      run_pkt("t5r", 2, 3, 1, 1'b0);

      run_pkt("t6", 2, 3, 1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
